// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// 8N1 UART transmitter fed by a small byte FIFO. Bytes pushed through a
// valid/ready handshake are serialized LSB first onto an idle-high line:
// one start bit (0), eight data bits, one stop bit (1), each held for
// CLK_DIV clock cycles.
//
// Parameters
//   CLK_DIV     clock cycles per serial bit (2..65535)
//   FIFO_DEPTH  FIFO entries (power of 2, >= 2)
//
// Ports
//   wb_clk_i    single clock
//   wb_rst_i    synchronous active-high reset (aborts any frame, flushes FIFO)
//   tx_data     byte to enqueue
//   tx_valid    tx_data is valid
//   tx_ready    FIFO can accept a byte (registered !full)
//   tx_en       permits new frames to start (sampled only at frame start)
//   ser_tx      serial output, idle high, driven from a register
//   busy        transmitter active or FIFO non-empty
//   fifo_level  number of bytes currently queued
//   tx_done     one-cycle pulse at the end of each stop bit
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_DIV    = 1042,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic                               tx_en,
    output logic                               ser_tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               tx_done
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    // Baud counter is 16 bits wide so that any CLK_DIV up to 65535 fits.
    localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_EMPTY = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Pointer advance; FIFO_DEPTH is a power of two so natural overflow wraps.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_ONE;
    endfunction

    // Next occupancy from the push/pop pair of this edge.
    function automatic logic [LVL_W-1:0] level_next(
        input logic [LVL_W-1:0] level,
        input logic             push,
        input logic             pop
    );
        logic [LVL_W-1:0] result;
        case ({push, pop})
            2'b10:   result = level + LVL_ONE;
            2'b01:   result = level - LVL_ONE;
            default: result = level;
        endcase
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             ready_r;

    state_t           state_r;
    logic [15:0]      baud_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             ser_tx_r;
    logic             done_r;
    logic             busy_r;

    // Combinational next values
    state_t           state_s;
    logic [15:0]      baud_s;
    logic [2:0]       bit_idx_s;
    logic [7:0]       shift_s;
    logic             ser_tx_s;
    logic             done_s;
    logic             pop_s;
    logic             push_s;
    logic             baud_end_s;
    logic             can_start_s;
    logic [7:0]       head_s;
    logic [LVL_W-1:0] level_s;
    logic             ready_s;
    logic             busy_s;

    // FIFO handshake and occupancy bookkeeping.
    always_comb begin
        // tx_ready is the registered !full flag, so a push can never land on a
        // full FIFO, even on an edge where a pop frees an entry.
        push_s      = tx_valid && ready_r;
        head_s      = mem_r[rd_ptr_r];
        can_start_s = (level_r != LVL_EMPTY) && tx_en;
        baud_end_s  = (baud_r == BAUD_LAST);
        level_s     = level_next(level_r, push_s, pop_s);
        ready_s     = (level_s != LVL_FULL);
        busy_s      = (state_s != ST_IDLE) || (level_s != LVL_EMPTY);
    end

    // Serializer FSM: next-state, baud counting, shift register and line value.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        ser_tx_s  = ser_tx_r;
        done_s    = 1'b0;
        pop_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                baud_s = 16'd0;
                if (can_start_s) begin
                    // Load the head byte and drive the start bit immediately.
                    pop_s    = 1'b1;
                    shift_s  = head_s;
                    state_s  = ST_START;
                    ser_tx_s = 1'b0;
                end else begin
                    ser_tx_s = 1'b1;
                end
            end

            ST_START: begin
                if (baud_end_s) begin
                    baud_s    = 16'd0;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                    ser_tx_s  = shift_r[0];
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end

            ST_DATA: begin
                if (baud_end_s) begin
                    baud_s = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_s  = ST_STOP;
                        ser_tx_s = 1'b1;
                    end else begin
                        // The line takes the next bit straight from the
                        // pre-shift value so it updates on the same edge.
                        shift_s   = {1'b0, shift_r[7:1]};
                        bit_idx_s = bit_idx_r + 3'd1;
                        ser_tx_s  = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end

            ST_STOP: begin
                if (baud_end_s) begin
                    baud_s = 16'd0;
                    done_s = 1'b1;
                    if (can_start_s) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop_s    = 1'b1;
                        shift_s  = head_s;
                        state_s  = ST_START;
                        ser_tx_s = 1'b0;
                    end else begin
                        state_s  = ST_IDLE;
                        ser_tx_s = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                baud_s    = 16'd0;
                bit_idx_s = 3'd0;
                ser_tx_s  = 1'b1;
            end
        endcase
    end

    // FSM state, counters and serializer registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            ser_tx_r  <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            ser_tx_r  <= ser_tx_s;
            done_r    <= done_s;
        end
    end

    // FIFO data array; contents need no reset because the pointers define validity.
    always_ff @(posedge wb_clk_i) begin
        if (push_s && !wb_rst_i) begin
            mem_r[wr_ptr_r] <= tx_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy, ready flag and busy flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_EMPTY;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            level_r <= level_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all straight from registers
    // -------------------------------------------------------------------------
    assign tx_ready   = ready_r;
    assign ser_tx     = ser_tx_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;
    assign tx_done    = done_r;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synthesizable 8N1 UART transmitter with a small input FIFO, clocked by the Wishbone clock in the user project area. Firmware-side logic (e.g. a Wishbone register or the FIR result path) pushes bytes through a valid/ready handshake. The block serializes them onto `ser_tx`, LSB first, idle-high, so the testbench UART monitor can display them. It is the transmit end of the serial link the monitor receives on.

## Interface
- `CLK_DIV`, default 1042: clock cycles per bit (10 MHz / 9600 baud); legal range 2..65535.
- `FIFO_DEPTH`, default 4: entries in the input FIFO; a power of 2, at least 2.

- `wb_clk_i` input 1: the single clock.
- `wb_rst_i` input 1: reset, synchronous and active-high.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: FIFO can accept a byte; equals !full.
- `tx_en` input 1: permits new frames to start.
- `ser_tx` output 1: serial line, idle high.
- `busy` output 1: state != IDLE or FIFO non-empty.
- `fifo_level` output $clog2(FIFO_DEPTH+1): entries currently held.
- `tx_done` output 1: one-cycle pulse at the end of each stop bit.

## Operation
- **Accept:** a byte is written at a rising edge where `tx_valid && tx_ready`. FIFO order is strict FIFO.
- **FSM states:** IDLE, START, DATA, STOP.
  - Each state holds its bit for exactly CLK_DIV cycles, counted by a baud counter that resets on every state/bit change.
  - IDLE: `ser_tx`=1. If FIFO non-empty and `tx_en`=1, pop the head into the shift register, go to START, `ser_tx`=0.
  - START: after CLK_DIV cycles go to DATA with bit index 0; `ser_tx`=shift[0].
  - DATA: after each CLK_DIV cycles, shift right and increment the bit index. After bit 7 completes, go to STOP with `ser_tx`=1.
  - STOP: after CLK_DIV cycles, pulse `tx_done`. Then:
    - if FIFO non-empty and `tx_en`=1, pop and go directly to START (no idle cycle);
    - otherwise go to IDLE.
- **Frame format:** exactly 10·CLK_DIV cycles, as 0, d0..d7, 1.
- **`ser_tx` output:** driven from a register; no combinational path from inputs.
- **`tx_en` low:** checked only at frame start. A frame in progress always completes; no new frame starts while `tx_en`=0. Bytes remain queued.
- **FIFO full:** `tx_ready`=0. A push attempted on a cycle where a pop also occurs is not accepted, because `tx_ready` comes from the registered full flag. `tx_valid` without `tx_ready` has no effect.
- **FIFO empty:** no pop; the FSM stays in IDLE.
- **Pointers:** wrap modulo FIFO_DEPTH. `fifo_level` is updated by +1 on push, −1 on pop, and is unchanged when both occur on the same edge.
- **Reset (including mid-frame):** the frame is aborted, the FIFO is flushed, and the FSM returns to IDLE.

## Timing
- **Reset values** (from the first edge with `wb_rst_i`=1):
  - `ser_tx`=1, `busy`=0, `fifo_level`=0, `tx_done`=0.
  - `tx_ready`=0 while `wb_rst_i`=1, and 1 at the first edge after release.
- **Latency:** a byte accepted at edge N into an empty FIFO in IDLE, with `tx_en`=1, drives `ser_tx` low from edge N+1. `fifo_level` reads 1 between N and N+1, and 0 after N+1.
- **`tx_done`:** high for the single cycle following edge N+1+10·CLK_DIV.
- **Back-to-back bytes:** consecutive start bits are exactly 10·CLK_DIV cycles apart.
- **`tx_en` rising** with a non-empty FIFO in IDLE: `ser_tx` goes low at the next edge.

## Test plan
Bench parameters: CLK_DIV=4, FIFO_DEPTH=4.
- **Single byte:** push 0xA5 -> `ser_tx` = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. Start is 1 cycle after accept; one `tx_done` pulse 40 cycles after start; `busy` falls the same cycle.
- **Back-to-back:** push 0x48, 0x69, 0x0A consecutively -> 120 contiguous frame cycles with no idle gap. A receiver monitor at 4 cycles/bit prints "Hi"; 3 `tx_done` pulses, 40 cycles apart.
- **Fill while disabled:** `tx_en`=0, offer 5 bytes 0x01..0x05 -> 4 accepted, `tx_ready`=0, `fifo_level`=4, `ser_tx` stays 1. Raise `tx_en` -> frames 0x01..0x04 in order; `tx_ready` returns 1 at the first pop.
- **Disable mid-frame:** queue 0x11 and 0x22, drop `tx_en` during 0x11's DATA state -> 0x11 completes intact. `ser_tx` stays high and `fifo_level`=1 until `tx_en` rises.
- **Reset mid-frame:** assert `wb_rst_i` for 1 cycle during bit 3 of 0x3C with 2 bytes queued -> next edge: `ser_tx`=1, `fifo_level`=0, `busy`=0, no `tx_done`. A subsequent push of 0x7E transmits correctly.
- **Full plus pop collision:** FIFO full with `tx_valid`=1 held on the STOP→START pop edge -> the byte is not accepted that edge. It is accepted the next edge, with `fifo_level` going 4→3→4.
